// File: rtl/agc_mem_pkg.sv
// Shared definitions for the AGC data-memory sequencer/arbiter.
package agc_mem_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CPU_SET = 3'd1,
    CPU_TP  = 3'd2,
    CNT_RD  = 3'd3,
    CNT_WR  = 3'd4,
    CNT_TP  = 3'd5,
    DONE    = 3'd6
  } state_t;

  // Hard-wired zero register; never writable.
  localparam logic [11:0] ZERO_ADDR   = 12'o7;
  // Any address with these bits set lies outside erasable memory.
  localparam logic [11:0] ERASE_MASK  = 12'hC00;

  // One's-complement +1 and -1 addends.
  localparam logic [14:0] ONES_PLUS1  = 15'h0001;
  localparam logic [14:0] ONES_MINUS1 = 15'h7FFE;

endpackage

// File: rtl/agc_mem_arbiter_ones_comp_incdec.sv
// 15-bit one's-complement increment/decrement with end-around carry.
// The two overflow cases wrap to the values the counter hardware expects.
module ones_comp_incdec
  import agc_mem_pkg::*;
(
  input  logic [14:0] v,
  input  logic        dir,
  output logic [14:0] result,
  output logic        ovf
);

  logic [15:0] sum;

  // Add +1 or -1, fold the carry back in, then override the overflow cases.
  always_comb begin
    sum    = {1'b0, v} + {1'b0, (dir ? ONES_MINUS1 : ONES_PLUS1)};
    result = sum[14:0] + {14'd0, sum[15]};
    ovf    = 1'b0;
    if (!dir && v == 15'h3FFF) begin
      result = 15'h0000;
      ovf    = 1'b1;
    end
    if (dir && v == 15'h4000) begin
      result = 15'h7FFF;
      ovf    = 1'b1;
    end
  end

endmodule

// File: rtl/agc_mem_arbiter.sv
// Single-port Data_memory sequencer: arbitrates CPU accesses against
// counter PINC/MINC read-modify-writes and generates a clean write strobe.
// All memory-side and handshake outputs are flops decoded from next state.
module agc_mem_arbiter #(
  parameter int                ADDR_W        = 12,
  parameter int                DATA_W        = 15,
  parameter logic [ADDR_W-1:0] ZERO_ADDR     = agc_mem_pkg::ZERO_ADDR,
  parameter int                CNT_BURST_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpuReq,
  input  logic              cpuWe,
  input  logic [ADDR_W-1:0] cpuAddr,
  input  logic [DATA_W-1:0] cpuWdata,
  output logic              cpuAck,
  output logic [DATA_W-1:0] cpuRdata,
  output logic              cpuErr,
  input  logic              cntReq,
  input  logic              cntDir,
  input  logic [ADDR_W-1:0] cntAddr,
  output logic              cntAck,
  output logic              cntErr,
  output logic              cntOvf,
  output logic [ADDR_W-1:0] memAddr,
  output logic [DATA_W-1:0] memDataIn,
  output logic              memWE,
  output logic              memTp,
  input  logic [DATA_W-1:0] memDataOut
);
  import agc_mem_pkg::*;

  localparam logic [2:0] BURST = 3'(CNT_BURST_MAX);

  function automatic logic wr_legal(input logic [ADDR_W-1:0] a);
    return ((a & ERASE_MASK) == '0) && (a != ZERO_ADDR);
  endfunction

  state_t            state, state_nx;
  logic [2:0]        streak;
  logic              we_q, legal_q, dir_q, ovf_q;
  logic              cpu_ok, cnt_ok, cpu_win, cnt_win, cpu_legal, cnt_legal;
  logic [DATA_W-1:0] inc_res;
  logic              inc_ovf;

  logic [ADDR_W-1:0] addr_nx;
  logic [DATA_W-1:0] din_nx;
  logic              we_nx, tp_nx;
  logic              cpu_ack_nx, cpu_err_nx, cnt_ack_nx, cnt_err_nx, cnt_ovf_nx;

  // Counter has priority unless it has starved a waiting CPU for a full burst.
  assign cpu_ok    = cpuReq & ~cpuAck;
  assign cnt_ok    = cntReq & ~cntAck;
  assign cpu_win   = cpu_ok & (~cnt_ok | (streak == BURST));
  assign cnt_win   = cnt_ok & ~cpu_win;
  assign cpu_legal = wr_legal(cpuAddr);
  assign cnt_legal = wr_legal(cntAddr);

  // Counter arithmetic works on the cell value being read this cycle.
  ones_comp_incdec u_incdec (
    .v      (memDataOut),
    .dir    (dir_q),
    .result (inc_res),
    .ovf    (inc_ovf)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state logic; grants happen only in IDLE.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (cpu_win)      state_nx = CPU_SET;
        else if (cnt_win) state_nx = cnt_legal ? CNT_RD : DONE;
      end
      CPU_SET: state_nx = CPU_TP;
      CPU_TP:  state_nx = DONE;
      CNT_RD:  state_nx = CNT_WR;
      CNT_WR:  state_nx = CNT_TP;
      CNT_TP:  state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Next output values; address/data/WE hold through DONE so they bracket memTp.
  always_comb begin
    addr_nx    = memAddr;
    din_nx     = memDataIn;
    we_nx      = memWE;
    tp_nx      = 1'b0;
    cpu_ack_nx = 1'b0;
    cpu_err_nx = 1'b0;
    cnt_ack_nx = 1'b0;
    cnt_err_nx = 1'b0;
    cnt_ovf_nx = 1'b0;
    case (state_nx)
      IDLE: we_nx = 1'b0;
      CPU_SET: begin
        addr_nx = cpuAddr;
        din_nx  = cpuWdata;
        we_nx   = cpuWe & cpu_legal;
      end
      CPU_TP: tp_nx = 1'b1;
      CNT_RD: begin
        addr_nx = cntAddr;
        we_nx   = 1'b0;
      end
      CNT_WR: begin
        din_nx = inc_res;
        we_nx  = 1'b1;
      end
      CNT_TP: tp_nx = 1'b1;
      DONE: begin
        if (state == CPU_TP) begin
          cpu_ack_nx = 1'b1;
          cpu_err_nx = we_q & ~legal_q;
        end else begin
          cnt_ack_nx = 1'b1;
          cnt_err_nx = (state == IDLE);
          cnt_ovf_nx = (state == CNT_TP) & ovf_q;
        end
      end
      default: ;
    endcase
  end

  // Output flops, request capture and CPU-starvation counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      memAddr   <= '0;
      memDataIn <= '0;
      memWE     <= 1'b0;
      memTp     <= 1'b0;
      cpuAck    <= 1'b0;
      cpuErr    <= 1'b0;
      cpuRdata  <= '0;
      cntAck    <= 1'b0;
      cntErr    <= 1'b0;
      cntOvf    <= 1'b0;
      streak    <= '0;
      we_q      <= 1'b0;
      legal_q   <= 1'b0;
      dir_q     <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      memAddr   <= addr_nx;
      memDataIn <= din_nx;
      memWE     <= we_nx;
      memTp     <= tp_nx;
      cpuAck    <= cpu_ack_nx;
      cpuErr    <= cpu_err_nx;
      cntAck    <= cnt_ack_nx;
      cntErr    <= cnt_err_nx;
      cntOvf    <= cnt_ovf_nx;
      if (state == IDLE && cpu_win) begin
        we_q    <= cpuWe;
        legal_q <= cpu_legal;
      end else if (state == IDLE && cnt_win) begin
        dir_q   <= cntDir;
      end
      if (state == CNT_RD) ovf_q    <= inc_ovf;
      if (state == CPU_TP) cpuRdata <= memDataOut;
      if (!cpuReq)                       streak <= '0;
      else if (state == IDLE && cpu_win) streak <= '0;
      else if (state == IDLE && cnt_win) streak <= streak + 3'd1;
    end
  end

endmodule

// File: tb/tb_agc_mem_arbiter.sv
// Directed bench for agc_mem_arbiter with a behavioural Data_memory model.
module tb_agc_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpuReq, cpuWe, cpuAck, cpuErr;
  logic [11:0] cpuAddr;
  logic [14:0] cpuWdata, cpuRdata;
  logic        cntReq, cntDir, cntAck, cntErr, cntOvf;
  logic [11:0] cntAddr;
  logic [11:0] memAddr;
  logic [14:0] memDataIn, memDataOut;
  logic        memWE, memTp;

  agc_mem_arbiter dut (
    .clk(clk), .reset(reset),
    .cpuReq(cpuReq), .cpuWe(cpuWe), .cpuAddr(cpuAddr), .cpuWdata(cpuWdata),
    .cpuAck(cpuAck), .cpuRdata(cpuRdata), .cpuErr(cpuErr),
    .cntReq(cntReq), .cntDir(cntDir), .cntAddr(cntAddr),
    .cntAck(cntAck), .cntErr(cntErr), .cntOvf(cntOvf),
    .memAddr(memAddr), .memDataIn(memDataIn), .memWE(memWE), .memTp(memTp),
    .memDataOut(memDataOut)
  );

  always #5 clk = ~clk;

  // Memory model: combinational read, write on the rising edge of tp.
  logic [14:0] mem [0:4095];
  logic        pre_stb = 1'b0;
  logic [11:0] pre_addr;
  logic [14:0] pre_data;
  int          tp_cnt = 0;

  assign memDataOut = mem[memAddr];

  always @(posedge memTp or posedge pre_stb) begin
    if (pre_stb)    mem[pre_addr] = pre_data;
    else if (memWE) mem[memAddr]  = memDataIn;
  end

  always @(posedge memTp) tp_cnt++;

  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic preload(input logic [11:0] a, input logic [14:0] d);
    pre_addr = a;
    pre_data = d;
    pre_stb  = 1'b1;
    #1;
    pre_stb  = 1'b0;
  endtask

  typedef struct {
    bit          is_cnt;
    bit          we_dir;
    logic [11:0] addr;
    logic [14:0] wdata;
    bit          pre;
    logic [14:0] init;
    logic [14:0] exp_cell;
    logic [14:0] exp_rdata;
    bit          exp_err;
    bit          exp_ovf;
    int          exp_tp;
    int          exp_ack;
    bit          exp_we;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs [NV];

  // Entered and left one tick after a rising edge with the DUT in IDLE.
  task automatic run_vec(input vec_t v, input int idx);
    int          tp_c, ack_c;
    bit          we_s;
    logic        err, ovf;
    logic [14:0] rd;
    if (v.pre) preload(v.addr, v.init);
    tp_c = -1; ack_c = -1; we_s = 1'b0; err = 1'b0; ovf = 1'b0; rd = '0;
    if (v.is_cnt) begin
      cntReq = 1'b1; cntDir = v.we_dir; cntAddr = v.addr;
    end else begin
      cpuReq = 1'b1; cpuWe = v.we_dir; cpuAddr = v.addr; cpuWdata = v.wdata;
    end
    for (int c = 1; c <= 20 && ack_c < 0; c++) begin
      @(posedge clk); #1;
      if (memTp && tp_c < 0) tp_c = c;
      if (memWE) we_s = 1'b1;
      if (v.is_cnt ? cntAck : cpuAck) begin
        ack_c = c;
        err   = v.is_cnt ? cntErr : cpuErr;
        ovf   = cntOvf;
        rd    = cpuRdata;
      end
    end
    cpuReq = 1'b0;
    cntReq = 1'b0;
    chk($sformatf("v%0d ack_cycle", idx), ack_c, v.exp_ack);
    chk($sformatf("v%0d tp_cycle", idx), tp_c, v.exp_tp);
    chk($sformatf("v%0d err", idx), {31'd0, err}, {31'd0, v.exp_err});
    chk($sformatf("v%0d ovf", idx), {31'd0, ovf}, {31'd0, v.exp_ovf});
    chk($sformatf("v%0d we_seen", idx), {31'd0, we_s}, {31'd0, v.exp_we});
    chk($sformatf("v%0d cell", idx), {17'd0, mem[v.addr]}, {17'd0, v.exp_cell});
    if (!v.is_cnt && !v.we_dir)
      chk($sformatf("v%0d rdata", idx), {17'd0, rd}, {17'd0, v.exp_rdata});
    @(posedge clk); #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " cpuAck"},    {31'd0, cpuAck},    0);
    chk({tag, " cpuErr"},    {31'd0, cpuErr},    0);
    chk({tag, " cpuRdata"},  {17'd0, cpuRdata},  0);
    chk({tag, " cntAck"},    {31'd0, cntAck},    0);
    chk({tag, " cntErr"},    {31'd0, cntErr},    0);
    chk({tag, " cntOvf"},    {31'd0, cntOvf},    0);
    chk({tag, " memAddr"},   {20'd0, memAddr},   0);
    chk({tag, " memDataIn"}, {17'd0, memDataIn}, 0);
    chk({tag, " memWE"},     {31'd0, memWE},     0);
    chk({tag, " memTp"},     {31'd0, memTp},     0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          tp0;
    int          grants [10];
    int          exp_g  [10];
    int          ng;

    //          cnt dir addr      wdata     pre init      cell      rdata     err ovf tp ack we
    vecs[0]  = '{0, 1, 12'h100, 15'h1234, 1, 15'h0000, 15'h1234, 15'h0000, 0, 0,  2, 3, 1};
    vecs[1]  = '{0, 0, 12'h100, 15'h0000, 0, 15'h0000, 15'h1234, 15'h1234, 0, 0,  2, 3, 0};
    vecs[2]  = '{1, 0, 12'h020, 15'h0000, 1, 15'h3FFF, 15'h0000, 15'h0000, 0, 1,  3, 4, 1};
    vecs[3]  = '{1, 1, 12'h021, 15'h0000, 1, 15'h0000, 15'h7FFE, 15'h0000, 0, 0,  3, 4, 1};
    vecs[4]  = '{1, 1, 12'h022, 15'h0000, 1, 15'h0001, 15'h7FFF, 15'h0000, 0, 0,  3, 4, 1};
    vecs[5]  = '{1, 1, 12'h023, 15'h0000, 1, 15'h4000, 15'h7FFF, 15'h0000, 0, 1,  3, 4, 1};
    vecs[6]  = '{1, 0, 12'h024, 15'h0000, 1, 15'h0005, 15'h0006, 15'h0000, 0, 0,  3, 4, 1};
    vecs[7]  = '{1, 0, 12'h025, 15'h0000, 1, 15'h7FFF, 15'h0001, 15'h0000, 0, 0,  3, 4, 1};
    vecs[8]  = '{1, 1, 12'h026, 15'h0000, 1, 15'h0005, 15'h0004, 15'h0000, 0, 0,  3, 4, 1};
    vecs[9]  = '{0, 1, 12'h800, 15'h5555, 1, 15'h0AAA, 15'h0AAA, 15'h0000, 1, 0,  2, 3, 0};
    vecs[10] = '{0, 1, 12'h007, 15'h5555, 1, 15'h0AAA, 15'h0AAA, 15'h0000, 1, 0,  2, 3, 0};
    vecs[11] = '{1, 0, 12'h400, 15'h0000, 1, 15'h0123, 15'h0123, 15'h0000, 1, 0, -1, 1, 0};
    vecs[12] = '{0, 1, 12'h3FF, 15'h7FFF, 1, 15'h0000, 15'h7FFF, 15'h0000, 0, 0,  2, 3, 1};
    vecs[13] = '{1, 1, 12'h007, 15'h0000, 1, 15'h0000, 15'h0000, 15'h0000, 1, 0, -1, 1, 0};
    vecs[14] = '{0, 0, 12'h800, 15'h0000, 1, 15'h2468, 15'h2468, 15'h2468, 0, 0,  2, 3, 0};

    reset = 1'b1;
    cpuReq = 1'b0; cpuWe = 1'b0; cpuAddr = '0; cpuWdata = '0;
    cntReq = 1'b0; cntDir = 1'b0; cntAddr = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    reset = 1'b0;

    for (int i = 0; i < NV; i++) run_vec(vecs[i], i);

    // Reset while the counter write data is set up but not yet strobed.
    preload(12'h050, 15'h0100);
    tp0 = tp_cnt;
    cntReq = 1'b1; cntDir = 1'b0; cntAddr = 12'h050;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("midreset in_cnt_wr memWE", {31'd0, memWE}, 1);
    reset  = 1'b1;
    cntReq = 1'b0;
    @(posedge clk); #1;
    chk_all_zero("midreset");
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("midreset tp_edges", tp_cnt - tp0, 0);
    chk("midreset cell", {17'd0, mem[12'h050]}, {17'd0, 15'h0100});

    // Both requesters held high: four counter grants, then one CPU grant.
    preload(12'h060, 15'h0000);
    exp_g = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    for (int i = 0; i < 10; i++) grants[i] = 2;
    ng = 0;
    cpuReq = 1'b1; cpuWe = 1'b0; cpuAddr = 12'h100;
    cntReq = 1'b1; cntDir = 1'b0; cntAddr = 12'h060;
    for (int c = 0; c < 80 && ng < 10; c++) begin
      @(posedge clk); #1;
      if (cntAck) begin grants[ng] = 1; ng++; end
      else if (cpuAck) begin grants[ng] = 0; ng++; end
    end
    cpuReq = 1'b0;
    cntReq = 1'b0;
    for (int i = 0; i < 10; i++)
      chk($sformatf("arb grant%0d (1=cnt)", i), grants[i], exp_g[i]);
    chk("arb counter cell", {17'd0, mem[12'h060]}, {17'd0, 15'h0008});
    chk("arb cpu rdata", {17'd0, cpuRdata}, {17'd0, 15'h1234});
    @(posedge clk); #1;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/agc_mem_arbiter.md
# agc_mem_arbiter

Sequencer and arbiter for the single port of the AGC `Data_memory` block. It shares the port between the CPU and the involuntary counter unit, which performs PINC/MINC read-modify-write cycles on counter cells. It generates the write timing pulse (`memTp`) and blocks illegal writes, so no requester drives the memory directly. It sits between the control unit / counter unit and `Data_memory`.

## Interface
- `ADDR_W`, 12, memory address width
- `DATA_W`, 15, word width (one's-complement arithmetic is defined for 15 only)
- `ZERO_ADDR`, 12'o7, write-protected zero register
- `CNT_BURST_MAX`, 4, maximum consecutive counter grants while CPU waits

- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high
- `cpuReq`  in  1  CPU request, held until `cpuAck`
- `cpuWe`  in  1  1 = write, 0 = read
- `cpuAddr`  in  12  CPU address
- `cpuWdata`  in  15  CPU write data
- `cpuAck`  out  1  one-cycle completion pulse
- `cpuRdata`  out  15  read data, valid with `cpuAck`, held until next CPU access
- `cpuErr`  out  1  with `cpuAck`: write blocked
- `cntReq`  in  1  counter request, held until `cntAck`
- `cntDir`  in  1  0 = PINC, 1 = MINC
- `cntAddr`  in  12  counter cell address
- `cntAck`  out  1  one-cycle completion pulse
- `cntErr`  out  1  with `cntAck`: illegal counter address, no access
- `cntOvf`  out  1  with `cntAck`: increment overflowed
- `memAddr`  out  12  to `Data_memory.Addr`
- `memDataIn`  out  15  to `Data_memory.DataIn`
- `memWE`  out  1  to `Data_memory.regWE`
- `memTp`  out  1  to `Data_memory.tp`, glitch-free flop output
- `memDataOut`  in  15  from `Data_memory.DataOut` (combinational read)

## Operation
- States: `IDLE`, `CPU_SET`, `CPU_TP`, `CNT_RD`, `CNT_WR`, `CNT_TP`, `DONE`.
- **Arbitration (IDLE only):**
  - Counter has priority over the CPU.
  - `streak` (3-bit) counts consecutive counter grants made while `cpuReq` is high.
  - When `streak == CNT_BURST_MAX` and `cpuReq` is high, the CPU wins.
  - `streak` clears on a CPU grant, or whenever `cpuReq` is low.
  - A requester whose ack is high in the current cycle is ignored.
- **Legality:** an address is legal for writing iff `addr[11:10] == 2'b00` and `addr != ZERO_ADDR`.
- **CPU path:** `IDLE` → `CPU_SET` → `CPU_TP` → `DONE` → `IDLE`.
  - `CPU_SET`: `memAddr`/`memDataIn` loaded; `memWE = cpuWe & legal`; `memTp = 0`.
  - `CPU_TP`: `memTp = 1`; `cpuRdata` captured from `memDataOut` at end of cycle.
  - `DONE`: `cpuAck = 1`; `cpuErr = cpuWe & ~legal`.
  - Reads are always legal.
- **Counter path:**
  - Illegal `cntAddr`: `IDLE` → `DONE` with `cntErr = 1`; no memory cycle.
  - Legal: `IDLE` → `CNT_RD` → `CNT_WR` → `CNT_TP` → `DONE`.
  - `CNT_RD`: address driven, `memWE = 0`; `memDataOut` latched as `v`.
  - `CNT_WR`: `memDataIn = f(v)`, `memWE = 1`, `memTp = 0`.
  - `CNT_TP`: `memTp = 1`.
  - `DONE`: `cntAck = 1`; `cntOvf` as below.
- **Arithmetic (15-bit one's complement, end-around carry):**
  - PINC: `v + 15'o00001`. Special case `v == 0x3FFF` → `0x0000`, `ovf = 1`.
  - MINC: `v + 0x7FFE`. Special case `v == 0x4000` → `0x7FFF` (−0), `ovf = 1`.
  - Otherwise `ovf = 0`.

## Timing
- Reset (synchronous): state `IDLE`, `streak = 0`, and every output low or zero (`cpuRdata = 0`).
- Reset mid-operation: the next cycle has `memTp = 0` and `memWE = 0`.
  - A write not yet strobed is lost; the memory cell is unchanged.
  - Requests still high after reset are re-arbitrated.
- Cycle 0 is the edge where `IDLE` samples the request.
  - CPU: `memTp` is high in cycle 2; `cpuAck` is in cycle 3. Back-to-back CPU accesses are possible every 4 cycles.
  - Counter: `memTp` is high in cycle 3; `cntAck` is in cycle 4.
- `memAddr`, `memDataIn` and `memWE` are stable for at least one full cycle before the `memTp` rising edge, and until the cycle after it falls.
- Simultaneous legal requests: exactly one is granted per `IDLE` cycle; the other waits.

## Structure
- Shared package `agc_mem_pkg`:
  - state encoding;
  - `ZERO_ADDR`;
  - erasable-region mask;
  - `ONES_PLUS1 = 15'h0001` and `ONES_MINUS1 = 15'h7FFE`.
- One combinational sub-module, `ones_comp_incdec`: inputs `v` and `dir`; outputs `result` and `ovf`.

## Test plan
- CPU write `0x100 ← 0x1234`, then a CPU read of `0x100`:
  - `memTp` rises in cycle 2 with `memWE = 1`;
  - the read returns `cpuRdata = 0x1234` with `cpuErr = 0`.
- PINC on `0x020` holding `0x3FFF`: the cell becomes `0x0000`; `cntOvf = 1` with `cntAck` in cycle 4.
- MINC sequences:
  - on `0x0000`: cell becomes `0x7FFE`;
  - on `0x0001`: cell becomes `0x7FFF`;
  - on `0x4000`: cell becomes `0x7FFF` with `cntOvf = 1`.
- Blocked writes:
  - CPU write to `0x800`: `memWE` never goes high; `cpuErr = 1` with `cpuAck`; memory unchanged.
  - CPU write to `0x007`: same result.
  - PINC on `0x400`: `cntErr = 1`; no `memTp`.
- `cpuReq` and `cntReq` both held high continuously: the grant sequence is 4 counter cycles, then 1 CPU cycle, repeating.
- `reset` pulsed during `CNT_WR`: `memTp` never rises; all outputs are 0 in the next cycle; the target cell is unchanged.
